// File: rtl/key_event.sv
// Gesture classifier for one debounced key: click, double click, long press
// and auto-repeat, each reported as a registered one-cycle pulse.
module key_event #(
  parameter int unsigned NBITS         = 28,
  parameter int unsigned LONG_CYCLES   = 100_000_000,
  parameter int unsigned DOUBLE_GAP    = 30_000_000,
  parameter int unsigned REPEAT_CYCLES = 20_000_000,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_o,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic [NBITS-1:0] LONG_LAST = NBITS'(LONG_CYCLES - 1);
  localparam logic [NBITS-1:0] GAP_LAST  = NBITS'(DOUBLE_GAP - 1);
  localparam logic [NBITS-1:0] REP_LAST  =
    NBITS'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam logic [NBITS-1:0] CNT_MAX   = '1;

  state_t            state, state_n;
  logic [NBITS-1:0]  count, count_n;
  logic              prev;
  logic              pressed_c, press_edge_c;
  logic              click_n, double_n, long_n, repeat_n;

  assign pressed_c    = key_i ^ ACTIVE_LOW;
  assign press_edge_c = pressed_c & ~prev;

  // Next-state, counter and event decode
  always_comb begin
    state_n  = state;
    count_n  = count;
    click_n  = 1'b0;
    double_n = 1'b0;
    long_n   = 1'b0;
    repeat_n = 1'b0;
    case (state)
      IDLE: begin
        if (press_edge_c) begin
          state_n = PRESS1;
          count_n = '0;
        end
      end
      PRESS1: begin
        if (!pressed_c) begin
          state_n = GAP;
          count_n = '0;
        end else if (count == LONG_LAST) begin
          state_n = HOLD;
          count_n = '0;
          long_n  = 1'b1;
        end else begin
          count_n = count + NBITS'(1);
        end
      end
      GAP: begin
        // A press landing on the timeout edge still counts as the second press
        if (press_edge_c) begin
          state_n = PRESS2;
          count_n = '0;
        end else if (count == GAP_LAST) begin
          state_n = IDLE;
          count_n = '0;
          click_n = 1'b1;
        end else begin
          count_n = count + NBITS'(1);
        end
      end
      PRESS2: begin
        if (!pressed_c) begin
          state_n  = IDLE;
          double_n = 1'b1;
        end
      end
      HOLD: begin
        if (!pressed_c) begin
          state_n = IDLE;
          count_n = '0;
        end else if ((REPEAT_CYCLES != 0) && (count == REP_LAST)) begin
          count_n  = '0;
          repeat_n = 1'b1;
        end else if (count != CNT_MAX) begin
          count_n = count + NBITS'(1);
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  // prev resets high so a key held through reset must be released first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      prev         <= 1'b1;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_o     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      prev         <= pressed_c;
      click        <= click_n;
      double_click <= double_n;
      long_press   <= long_n;
      repeat_o     <= repeat_n;
      busy         <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: three instances (repeat on, repeat off, active-low key)
// compared every cycle against a timestamp-based gesture model.
module tb_key_event;

  localparam int L = 20;
  localparam int G = 8;
  localparam int R0 = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic key;
  logic key_n;

  logic click_m, dbl_m, long_m, rep_m, busy_m;
  logic click_z, dbl_z, long_z, rep_z, busy_z;
  logic click_l, dbl_l, long_l, rep_l, busy_l;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model state per instance: 0 = repeat 5, 1 = repeat disabled
  int rep_per [2] = '{R0, 0};
  int mode [2];
  int t_start [2];
  int t_rel [2];
  int t_hold [2];
  bit mprev [2];
  bit ec [2], ed [2], el [2], er [2], eb [2];

  // observed pulse tallies per instance (main, norep, active-low)
  int n_click [3], n_dbl [3], n_long [3], n_rep [3];

  assign key_n = ~key;

  always #5 clk = ~clk;

  key_event #(.NBITS(8), .LONG_CYCLES(L), .DOUBLE_GAP(G), .REPEAT_CYCLES(R0), .ACTIVE_LOW(1'b0)) u_main (
    .clk(clk), .rst_n(rst_n), .key_i(key), .click(click_m), .double_click(dbl_m),
    .long_press(long_m), .repeat_o(rep_m), .busy(busy_m));

  key_event #(.NBITS(8), .LONG_CYCLES(L), .DOUBLE_GAP(G), .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b0)) u_norep (
    .clk(clk), .rst_n(rst_n), .key_i(key), .click(click_z), .double_click(dbl_z),
    .long_press(long_z), .repeat_o(rep_z), .busy(busy_z));

  key_event #(.NBITS(8), .LONG_CYCLES(L), .DOUBLE_GAP(G), .REPEAT_CYCLES(R0), .ACTIVE_LOW(1'b1)) u_low (
    .clk(clk), .rst_n(rst_n), .key_i(key_n), .click(click_l), .double_click(dbl_l),
    .long_press(long_l), .repeat_o(rep_l), .busy(busy_l));

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; mprev[i] = 1'b1;
      ec[i] = 0; ed[i] = 0; el[i] = 0; er[i] = 0; eb[i] = 0;
    end
  endtask

  // Gesture rules in terms of time since press / release / hold start
  task automatic model_edge(input int i, input bit p, input int n);
    bit pe;
    pe = p & ~mprev[i];
    ec[i] = 0; ed[i] = 0; el[i] = 0; er[i] = 0;
    case (mode[i])
      0: if (pe) begin mode[i] = 1; t_start[i] = n; end
      1: if (!p) begin mode[i] = 2; t_rel[i] = n; end
         else if (n - t_start[i] == L) begin el[i] = 1; mode[i] = 4; t_hold[i] = n; end
      2: if (pe) mode[i] = 3;
         else if (n - t_rel[i] == G) begin ec[i] = 1; mode[i] = 0; end
      3: if (!p) begin ed[i] = 1; mode[i] = 0; end
      default: if (!p) mode[i] = 0;
               else if (rep_per[i] != 0 && (n - t_hold[i]) % rep_per[i] == 0) er[i] = 1;
    endcase
    eb[i] = (mode[i] != 0);
    mprev[i] = p;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("main.click", click_m, ec[0]);  chk("main.double_click", dbl_m, ed[0]);
    chk("main.long_press", long_m, el[0]); chk("main.repeat_o", rep_m, er[0]);
    chk("main.busy", busy_m, eb[0]);
    chk("norep.click", click_z, ec[1]); chk("norep.double_click", dbl_z, ed[1]);
    chk("norep.long_press", long_z, el[1]); chk("norep.repeat_o", rep_z, er[1]);
    chk("norep.busy", busy_z, eb[1]);
    chk("low.click", click_l, ec[0]);   chk("low.double_click", dbl_l, ed[0]);
    chk("low.long_press", long_l, el[0]); chk("low.repeat_o", rep_l, er[0]);
    chk("low.busy", busy_l, eb[0]);
  endtask

  task automatic clear_tally();
    for (int i = 0; i < 3; i++) begin
      n_click[i] = 0; n_dbl[i] = 0; n_long[i] = 0; n_rep[i] = 0;
    end
  endtask

  // One clock: drive the key level, let the edge happen, then compare
  task automatic step(input bit k);
    key = k;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      model_edge(0, k, cyc);
      model_edge(1, k, cyc);
    end
    #1;
    check_all();
    n_click[0] += int'(click_m); n_dbl[0] += int'(dbl_m); n_long[0] += int'(long_m); n_rep[0] += int'(rep_m);
    n_click[1] += int'(click_z); n_dbl[1] += int'(dbl_z); n_long[1] += int'(long_z); n_rep[1] += int'(rep_z);
    n_click[2] += int'(click_l); n_dbl[2] += int'(dbl_l); n_long[2] += int'(long_l); n_rep[2] += int'(rep_l);
  endtask

  task automatic hold(input bit k, input int n);
    for (int j = 0; j < n; j++) step(k);
  endtask

  task automatic expect_tally(input string name, input int c, input int d, input int lp, input int r_main, input int r_norep);
    for (int i = 0; i < 3; i++) begin
      chk_cnt({name, ".clicks"}, n_click[i], c);
      chk_cnt({name, ".doubles"}, n_dbl[i], d);
      chk_cnt({name, ".longs"}, n_long[i], lp);
      chk_cnt({name, ".repeats"}, n_rep[i], (i == 1) ? r_norep : r_main);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key = 1'b0;
    model_reset();
    clear_tally();

    // reset state
    hold(1'b0, 3);
    rst_n = 1'b1;
    hold(1'b0, 3);

    // single click
    clear_tally();
    hold(1'b1, 5); hold(1'b0, 12);
    expect_tally("click", 1, 0, 0, 0, 0);
    chk("click.busy_after", busy_m, 1'b0);

    // double click
    clear_tally();
    hold(1'b1, 5); hold(1'b0, 3); hold(1'b1, 4); hold(1'b0, 12);
    expect_tally("double", 0, 1, 0, 0, 0);

    // long press with repeat, release silent
    clear_tally();
    hold(1'b1, 36); hold(1'b0, 4);
    expect_tally("long", 0, 0, 1, 3, 0);

    // release on the long threshold edge
    clear_tally();
    hold(1'b1, L); hold(1'b0, 12);
    expect_tally("long_edge", 1, 0, 0, 0, 0);

    // second press on the gap timeout edge
    clear_tally();
    hold(1'b1, 3); hold(1'b0, G); hold(1'b1, 2); hold(1'b0, 12);
    expect_tally("gap_edge", 0, 1, 0, 0, 0);

    // asynchronous reset mid-press, key held through it
    clear_tally();
    hold(1'b1, 3);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    hold(1'b1, 2);
    rst_n = 1'b1;
    hold(1'b1, 30);
    expect_tally("held_reset", 0, 0, 0, 0, 0);
    chk("held_reset.busy", busy_m, 1'b0);
    hold(1'b0, 2);
    clear_tally();
    hold(1'b1, 5); hold(1'b0, 12);
    expect_tally("post_reset_click", 1, 0, 0, 0, 0);

    // random key activity
    for (int g = 0; g < 80; g++) begin
      hold(1'(g % 2 == 0), int'($urandom_range(1, 30)));
    end
    hold(1'b0, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Consumes the clean, already-synchronized level from the key debouncer and classifies each user gesture on it.
- Gestures: single click, double click, long press, and auto-repeat while the key is held.
- Every event is emitted as a one-cycle pulse for downstream control logic (mode/counter/display FSMs).
- Sits directly after the debouncer, one instance per key.

Parameters:
- NBITS, 28: width of the internal interval counter. All interval parameters must be < 2^NBITS.
- LONG_CYCLES, 100_000_000: cycles the key must stay held before long_press fires (1 s at 100 MHz). Must be >= 1.
- DOUBLE_GAP, 30_000_000: maximum release-to-second-press window for double_click (0.3 s). Must be >= 1.
- REPEAT_CYCLES, 20_000_000: auto-repeat period while held after long_press. 0 disables repeat.
- ACTIVE_LOW, 0: 1 means key_i = 0 is the pressed level.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- key_i  input  1  debounced key level, already synchronous to clk.
- click  output  1  one-cycle pulse: single click completed.
- double_click  output  1  one-cycle pulse: second release of a double click.
- long_press  output  1  one-cycle pulse: hold reached LONG_CYCLES.
- repeat_o  output  1  one-cycle pulse: each auto-repeat period while held.
- busy  output  1  high whenever the FSM is not in IDLE (registered).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Definitions:
  - pressed = key_i XOR ACTIVE_LOW.
  - prev = pressed value registered on the previous edge.
  - press edge = pressed & ~prev. Release = ~pressed in the states below.
- Reset values: all outputs 0, state IDLE, count 0, prev = 1.
  - prev resets to 1 so a key held through reset is ignored until it is released and pressed again.
  - Reset asserted mid-gesture aborts it with no pulse.
- Registers: all outputs are registered. Pulses are exactly one cycle wide. At most one event pulse is high in any cycle.
- E0 = the edge at which a press edge is sampled in IDLE.
- IDLE: on press edge -> PRESS1, count = 0. Otherwise stay.
- PRESS1, evaluated on each edge:
  - Released -> GAP, count = 0.
  - Else if count == LONG_CYCLES-1 -> HOLD, count = 0, long_press = 1. long_press is therefore high after edge E0+LONG_CYCLES.
  - Else count++.
  - Release sampled on the same edge as the long threshold: release wins -> GAP, no long_press.
- GAP (released; Er = entry edge):
  - Press edge -> PRESS2.
  - Else if count == DOUBLE_GAP-1 -> IDLE, click = 1. click is therefore high after edge Er+DOUBLE_GAP.
  - Else count++.
  - Press edge on the timeout edge: press wins -> PRESS2, no click.
- PRESS2:
  - Wait for release, then -> IDLE, double_click = 1 on that edge.
  - No long-press detection in PRESS2; an arbitrarily long second hold still ends in double_click.
- HOLD, while pressed:
  - If REPEAT_CYCLES != 0 and count == REPEAT_CYCLES-1 -> repeat_o = 1, count = 0.
  - Else count++; when REPEAT_CYCLES == 0, count saturates at all-ones and never fires.
  - First repeat_o appears after edge E0+LONG_CYCLES+REPEAT_CYCLES, then every REPEAT_CYCLES.
  - Release -> IDLE, no pulse.
- busy: 1 whenever the next state is not IDLE, registered alongside state.
- A triple press is treated as a double click (ends at the second release) followed by a fresh gesture starting at the third press.
- Counter width: count is NBITS wide. No wrap is possible with legal parameters.

Test Plan (LONG_CYCLES=20, DOUBLE_GAP=8, REPEAT_CYCLES=5, ACTIVE_LOW=0 unless stated):
- Click: press 5 cycles, release, stay idle -> exactly one click pulse, 8 cycles after the release edge. No other pulses. busy low afterwards.
- Double click: press 5, release 3, press 4, release -> exactly one double_click on the second release edge. No click.
- Long press with repeat: hold 36 cycles from E0 -> long_press after E0+20, repeat_o after E0+25, E0+30, E0+35. No pulse on release. Repeat with REPEAT_CYCLES=0 -> long_press only.
- Boundaries:
  - Release sampled exactly at E0+20 -> no long_press; click 8 cycles later.
  - Second press sampled exactly at the GAP timeout edge -> double_click, no click.
- Reset and held key:
  - Assert rst_n low mid-PRESS1 -> all outputs 0 immediately (asynchronous).
  - Release reset with the key still held for 30 cycles -> no events.
  - Release the key, then click -> normal click.
- ACTIVE_LOW=1: the click scenario with inverted key_i -> the same click timing.
